// File: rtl/rr_arb_pkg.sv
// Shared types, defaults and the round-robin index helper for rr_tenure_arbiter.
package rr_arb_pkg;

  localparam int unsigned DefN         = 4;
  localparam int unsigned DefHoldW     = 8;
  localparam int unsigned DefGapCycles = 1;

  typedef enum logic [1:0] {StIdle, StOwn, StGap} arb_state_e;

  // Index of the k-th candidate after ptr, wrapping modulo n (ptr < n, k < n).
  function automatic int unsigned rr_idx(input int unsigned ptr, input int unsigned k,
                                         input int unsigned n);
    int unsigned s;
    s = ptr + 32'd1 + k;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req found after ptr, wrapping.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned N   = DefN,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   pick,
  output logic [IDW-1:0] pick_id,
  output logic           any
);

  logic [IDW-1:0] idx;

  always_comb begin
    pick    = '0;
    pick_id = '0;
    any     = 1'b0;
    idx     = '0;
    for (int k = 0; k < int'(N); k++) begin
      idx = IDW'(rr_idx(32'(ptr), k, N));
      if (!any && req[idx]) begin
        any       = 1'b1;
        pick[idx] = 1'b1;
        pick_id   = idx;
      end
    end
  end

endmodule

// File: rtl/rr_tenure_arbiter.sv
// Round-robin bus arbiter with bounded tenure, timeout preemption and an owner turnaround gap.
module rr_tenure_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned N          = DefN,
  parameter int unsigned IDW        = $clog2(N),
  parameter int unsigned HOLD_W     = DefHoldW,
  parameter int unsigned GAP_CYCLES = DefGapCycles
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req,
  input  logic              cfg_en,
  input  logic [HOLD_W-1:0] cfg_max_hold,
  output logic [N-1:0]      gnt,
  output logic              gnt_valid,
  output logic [IDW-1:0]    gnt_id,
  output logic              preempt
);

  localparam int unsigned    GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned    GapLast = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [IDW-1:0] PtrRst  = IDW'(N - 1);

  arb_state_e        state_q;
  logic [IDW-1:0]    ptr_q;
  logic [HOLD_W-1:0] cnt_q;
  logic [GapW-1:0]   gap_q;
  logic [N-1:0]      gnt_q;
  logic              gnt_valid_q;
  logic [IDW-1:0]    gnt_id_q;
  logic              preempt_q;

  logic [N-1:0]   pick;
  logic [IDW-1:0] pick_id;
  logic           any;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .pick    (pick),
    .pick_id (pick_id),
    .any     (any)
  );

  logic owner_req, others, timeout, tenure_end, arb_now;

  // cfg_max_hold is compared live so lowering it mid-tenure takes effect at once.
  assign owner_req  = |(req & gnt_q);
  assign others     = |(req & ~gnt_q);
  assign timeout    = (cfg_max_hold != '0) && (cnt_q >= cfg_max_hold) && others;
  assign tenure_end = (state_q == StOwn) && (!owner_req || timeout);
  assign arb_now    = cfg_en && any &&
                      ((state_q == StIdle) || ((state_q == StGap) && (gap_q == '0)) ||
                       (tenure_end && (GAP_CYCLES == 0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= PtrRst;
      cnt_q       <= '0;
      gap_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      preempt_q   <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      unique case (state_q)
        StIdle: state_q <= StIdle;
        StOwn: begin
          if (tenure_end) begin
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            // Owner still requesting at tenure end means it was revoked by timeout.
            preempt_q   <= owner_req;
            state_q     <= (GAP_CYCLES > 0) ? StGap : StIdle;
            gap_q       <= GapW'(GapLast);
          end else if (!(&cnt_q)) begin
            cnt_q <= cnt_q + HOLD_W'(1);
          end
        end
        StGap: begin
          if (gap_q == '0) state_q <= StIdle;
          else             gap_q   <= gap_q - GapW'(1);
        end
        default: state_q <= StIdle;
      endcase
      // A new grant overrides the idle/release bookkeeping above.
      if (arb_now) begin
        state_q     <= StOwn;
        gnt_q       <= pick;
        gnt_valid_q <= 1'b1;
        gnt_id_q    <= pick_id;
        ptr_q       <= pick_id;
        cnt_q       <= HOLD_W'(1);
      end
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_tenure_arbiter.sv
// Directed bench for rr_tenure_arbiter: a GAP_CYCLES=1 instance and a GAP_CYCLES=0 instance.
module tb_rr_tenure_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       cfg_en;
  logic [7:0] cfg_max_hold;

  logic [3:0] gnt, gnt0;
  logic       gnt_valid, gnt_valid0;
  logic [1:0] gnt_id, gnt_id0;
  logic       preempt, preempt0;

  int n_vec = 0;
  int n_err = 0;

  rr_tenure_arbiter #(
    .N          (4),
    .HOLD_W     (8),
    .GAP_CYCLES (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .cfg_en       (cfg_en),
    .cfg_max_hold (cfg_max_hold),
    .gnt          (gnt),
    .gnt_valid    (gnt_valid),
    .gnt_id       (gnt_id),
    .preempt      (preempt)
  );

  rr_tenure_arbiter #(
    .N          (4),
    .HOLD_W     (8),
    .GAP_CYCLES (0)
  ) dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .cfg_en       (cfg_en),
    .cfg_max_hold (cfg_max_hold),
    .gnt          (gnt0),
    .gnt_valid    (gnt_valid0),
    .gnt_id       (gnt_id0),
    .preempt      (preempt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Synchronously aligned reset pulse; inputs applied while in reset.
  task automatic do_reset(input logic [3:0] r, input logic [7:0] hold);
    rst_n        = 1'b0;
    req          = r;
    cfg_en       = 1'b1;
    cfg_max_hold = hold;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int o;
    rst_n        = 1'b0;
    req          = 4'b1111;
    cfg_en       = 1'b1;
    cfg_max_hold = 8'd0;
    tick();
    tick();

    // Reset state
    check_eq("rst_gnt", 32'(gnt), 32'h0);
    check_eq("rst_valid", 32'(gnt_valid), 32'h0);
    check_eq("rst_preempt", 32'(preempt), 32'h0);
    check_eq("rst_id", 32'(gnt_id), 32'h0);
    rst_n = 1'b1;
    tick();
    check_eq("first_gnt", 32'(gnt), 32'h1);
    check_eq("first_id", 32'(gnt_id), 32'h0);
    check_eq("first_valid", 32'(gnt_valid), 32'h1);

    // Fairness: order 0,1,2,3,0 with one idle cycle between owners
    for (int i = 0; i < 5; i++) begin
      o = i % 4;
      check_eq("fair_gnt", 32'(gnt), 32'(4'b0001 << o));
      check_eq("fair_id", 32'(gnt_id), 32'(o));
      if (i < 4) begin
        tick();
        check_eq("fair_hold2", 32'(gnt), 32'(4'b0001 << o));
        tick();
        check_eq("fair_hold3", 32'(gnt), 32'(4'b0001 << o));
        req = 4'b1111 & ~(4'b0001 << o);
        tick();
        check_eq("fair_gap_gnt", 32'(gnt), 32'h0);
        check_eq("fair_gap_valid", 32'(gnt_valid), 32'h0);
        check_eq("fair_gap_id", 32'(gnt_id), 32'(o));
        req = 4'b1111;
        tick();
      end
    end

    // Timeout with max_hold=4; requester 2 arrives during tenure
    do_reset(4'b0001, 8'd4);
    tick();
    check_eq("to_g1", 32'(gnt), 32'h1);
    check_eq("to0_g1", 32'(gnt0), 32'h1);
    req = 4'b0101;
    tick();
    check_eq("to_g2", 32'(gnt), 32'h1);
    tick();
    check_eq("to_g3", 32'(gnt), 32'h1);
    tick();
    check_eq("to_g4", 32'({preempt, gnt}), 32'h01);
    check_eq("to0_g4", 32'({preempt0, gnt0}), 32'h01);
    tick();
    check_eq("to_gap_gnt", 32'(gnt), 32'h0);
    check_eq("to_gap_preempt", 32'(preempt), 32'h1);
    check_eq("to0_handover_gnt", 32'(gnt0), 32'h4);
    check_eq("to0_handover_preempt", 32'(preempt0), 32'h1);
    check_eq("to0_handover_id", 32'(gnt_id0), 32'h2);
    tick();
    check_eq("to_new_gnt", 32'(gnt), 32'h4);
    check_eq("to_new_preempt", 32'(preempt), 32'h0);
    check_eq("to_new_id", 32'(gnt_id), 32'h2);
    check_eq("to0_after", 32'({preempt0, gnt0}), 32'h04);

    // Lone owner never times out
    do_reset(4'b0010, 8'd4);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("lone", 32'({preempt, gnt}), 32'h02);
    end

    // Asynchronous reset mid-tenure
    do_reset(4'b0100, 8'd0);
    tick();
    check_eq("mid_pre", 32'(gnt), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_async_gnt", 32'(gnt), 32'h0);
    check_eq("mid_async_valid", 32'(gnt_valid), 32'h0);
    tick();
    rst_n = 1'b1;
    req   = 4'b1010;
    tick();
    check_eq("after_rst_gnt", 32'(gnt), 32'h2);
    check_eq("after_rst_id", 32'(gnt_id), 32'h1);

    // cfg_en=0 keeps the owner but blocks new grants
    cfg_en = 1'b0;
    tick();
    check_eq("en0_keep1", 32'(gnt), 32'h2);
    tick();
    check_eq("en0_keep2", 32'(gnt), 32'h2);
    req = 4'b1000;
    tick();
    check_eq("en0_release", 32'(gnt), 32'h0);
    tick();
    check_eq("en0_block1", 32'(gnt), 32'h0);
    tick();
    check_eq("en0_block2", 32'(gnt_valid), 32'h0);
    cfg_en = 1'b1;
    tick();
    check_eq("en1_gnt", 32'(gnt), 32'h8);
    check_eq("en1_id", 32'(gnt_id), 32'h3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rr_tenure_arbiter.md
Name: rr_tenure_arbiter

Overview:
N-way round-robin arbiter for a shared bus resource, with a bounded ownership tenure.
- A granted requester owns the resource until it drops its request, or until its tenure limit expires while others are waiting.
- A programmable turnaround gap separates successive owners.
- Sits between the requester ports and the shared bus mux; gnt and gnt_id drive the mux select.

Parameters:
N, 4, number of requesters (>=2)
IDW, $clog2(N), width of gnt_id
HOLD_W, 8, width of tenure counter and cfg_max_hold
GAP_CYCLES, 1, idle bus cycles forced between owners (0 = back-to-back handover)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req  in  N  request per requester, level; owner holds high while using the bus
cfg_en  in  1  1 = new grants allowed
cfg_max_hold  in  HOLD_W  max granted cycles per tenure when others wait; 0 = unlimited
gnt  out  N  one-hot grant, registered
gnt_valid  out  1  OR of gnt, registered
gnt_id  out  IDW  binary index of owner; holds last owner while gnt_valid=0
preempt  out  1  one-cycle pulse when a tenure is revoked by timeout

Behaviour:
- Reset (async assert, sync-released use): gnt=0, gnt_valid=0, gnt_id=0, preempt=0, state=IDLE, tenure cnt=0, last-owner ptr=N-1 so requester 0 has top priority first.
- Arbitration priority: search starts at ptr+1 and wraps modulo N; the first set req wins. The winner becomes the new ptr, so it has lowest priority next time.
- States: IDLE, OWN, GAP.
- IDLE:
  - If cfg_en & |req in cycle t: winner's gnt bit, gnt_valid and gnt_id are set at edge t+1.
  - At the same edge: cnt=1, state goes to OWN. Request-to-grant latency is 1 cycle.
- OWN, each cycle:
  - Release: owner req=0. gnt is cleared at the next edge.
  - Timeout: cfg_max_hold!=0, cnt>=cfg_max_hold, and some other req bit is set. gnt is cleared at the next edge and preempt=1 for exactly that one cycle.
  - Otherwise: cnt increments, saturating at all-ones. The owner keeps the grant.
  - cfg_max_hold is compared live, so lowering it mid-tenure below cnt triggers timeout at once if others wait.
  - No other requester pending: no timeout, ever.
- After a release or timeout:
  - GAP_CYCLES>0: state goes to GAP with gnt=0 for exactly GAP_CYCLES cycles. Arbitration is evaluated on req in the last GAP cycle, using the IDLE rules. With no eligible req, state goes to IDLE.
  - GAP_CYCLES=0: arbitration is evaluated in the release/timeout cycle itself. The new gnt replaces the old one at the same edge, and preempt coincides with the new grant.
  - On timeout the old owner is never re-selected ahead of the waiting requester, because ptr = old owner.
- cfg_en=0: blocks new grants only. A current owner is never revoked by cfg_en.
- Requests dropped during GAP are simply ineligible. The released owner's re-request has lowest priority.
- gnt is always one-hot or zero. gnt_valid == |gnt.

Decomposition:
- Package rr_arb_pkg:
  - state enum {IDLE, OWN, GAP}
  - rotate-from-pointer helper function
  - default parameter constants
- Sub-module rr_pick (combinational): inputs req and ptr; outputs one-hot pick, binary pick_id, and any.
- rr_tenure_arbiter holds the FSM, ptr, tenure counter, gap counter and output registers.

Test Plan (N=4, GAP_CYCLES=1 unless noted):
- Reset: rst_n=0 with req=4'b1111 -> gnt=0, gnt_valid=0, preempt=0. Then rst_n=1 with cfg_en=1 -> gnt=4'b0001 one cycle later, gnt_id=0.
- Fairness: cfg_max_hold=0, req=4'b1111, each owner drops req for 1 cycle after 3 granted cycles -> grant order 0,1,2,3,0, gnt=0 for exactly 1 cycle between owners.
- Timeout: cfg_max_hold=4, req0 held, req2 raised during tenure -> gnt0 for 4 cycles, then gnt=0 with preempt=1 for 1 cycle, then gnt=4'b0100.
- GAP_CYCLES=0 build, same stimulus -> gnt goes 4'b0001 to 4'b0100 on one edge, with preempt=1 that cycle.
- Lone owner: cfg_max_hold=4, only req1 high for 20 cycles -> gnt=4'b0010 for all 20 cycles, preempt never asserts.
- Reset mid-tenure and enable: with gnt=4'b0100, drop rst_n mid-cycle -> gnt=0 immediately. After release, with req=4'b1010 -> gnt=4'b0010. With cfg_en=0 and req=4'b1000 -> no grant; an existing owner keeps its grant until it drops req.
